// File: rtl/rv_pkg.sv
// Shared RV32I/RV64I decode definitions: opcodes, format codes, buffer states, decoded-instruction records.
package rv_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    // Encoding is {M.valid, S.valid}.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } buf_state_e;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } rv_fields_t;

    typedef struct packed {
        logic [31:0] pc;
        rv_fields_t  f;
        logic [31:0] imm;
        fmt_e        fmt;
        logic        illegal;
    } rv_dec32_t;

    typedef struct packed {
        logic [63:0] pc;
        rv_fields_t  f;
        logic [63:0] imm;
        fmt_e        fmt;
        logic        illegal;
    } rv_dec64_t;

    // Compressed encodings (inst[1:0] != 2'b11) never match because every base opcode ends in 11.
    function automatic fmt_e opcode_fmt(input logic [6:0] opc);
        fmt_e f;
        case (opc)
            OPC_LUI, OPC_AUIPC:                  f = FMT_U;
            OPC_JAL:                             f = FMT_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM,
            OPC_MISC_MEM, OPC_SYSTEM:            f = FMT_I;
            OPC_BRANCH:                          f = FMT_B;
            OPC_STORE:                           f = FMT_S;
            OPC_OP:                              f = FMT_R;
            default:                             f = FMT_ILL;
        endcase
        return f;
    endfunction

    function automatic rv_fields_t extract_fields(input logic [31:0] inst);
        rv_fields_t r;
        r.rs1    = inst[19:15];
        r.rs2    = inst[24:20];
        r.rd     = inst[11:7];
        r.opcode = inst[6:0];
        r.funct3 = inst[14:12];
        r.funct7 = inst[31:25];
        return r;
    endfunction

endpackage

// File: rtl/ifid_decode_stage_if.sv
// IF/ID stage bus: fetch-side handshake in, decoded execute-side bundle out.
interface ifid_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, rs1, rs2, rd, opcode,
               funct3, funct7, imm, fmt, illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, rs1, rs2, rd, opcode,
               funct3, funct7, imm, fmt, illegal
    );
endinterface

// File: rtl/rv_imm_gen.sv
// Combinational format classifier and sign-extended immediate generator for 32-bit instructions.
module rv_imm_gen
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    logic [31:0] imm32;

    always_comb begin
        fmt     = opcode_fmt(inst[6:0]);
        illegal = (fmt == FMT_ILL);
    end

    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm32 = {inst[31:12], 12'b0};
            FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Signed cast makes the width conversion replicate inst[31] up to XLEN.
    assign imm = XLEN'(signed'(imm32));

endmodule

// File: rtl/ifid_decode_stage.sv
// IF/ID stage: decodes fetched instructions into a main register M backed by a skid register S.
// in_ready is a flop; flush and async reset empty both entries.
module ifid_decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    ifid_decode_stage_if.slave bus
);

    // Same layout as rv_dec32_t / rv_dec64_t, sized by this instance's XLEN.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        rv_fields_t      f;
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
    } dec_t;

    dec_t            dec_in;
    logic [XLEN-1:0] imm_in;
    fmt_e            fmt_in;
    logic            ill_in;

    dec_t       m_q, s_q;
    buf_state_e state_q, state_d;
    logic       in_rdy_q, in_rdy_d;
    logic       accept;
    logic       m_ld_in, m_ld_skid, s_ld;

    rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst    (bus.in_inst),
        .imm     (imm_in),
        .fmt     (fmt_in),
        .illegal (ill_in)
    );

    always_comb begin
        dec_in.pc      = bus.in_pc;
        dec_in.f       = extract_fields(bus.in_inst);
        dec_in.imm     = imm_in;
        dec_in.fmt     = fmt_in;
        dec_in.illegal = ill_in;
    end

    assign accept = bus.in_valid && in_rdy_q && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            in_rdy_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            in_rdy_q <= in_rdy_d;
        end
    end

    // Flush outranks both accept and drain.
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_d = ST_ONE;
                ST_ONE: begin
                    if (accept && !bus.out_ready)      state_d = ST_FULL;
                    else if (!accept && bus.out_ready) state_d = ST_EMPTY;
                end
                ST_FULL:  if (bus.out_ready) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
        in_rdy_d = (state_d != ST_FULL);
    end

    always_comb begin
        m_ld_in   = 1'b0;
        m_ld_skid = 1'b0;
        s_ld      = 1'b0;
        if (!bus.flush) begin
            case (state_q)
                ST_EMPTY: m_ld_in = accept;
                ST_ONE: begin
                    m_ld_in = accept && bus.out_ready;
                    s_ld    = accept && !bus.out_ready;
                end
                ST_FULL:  m_ld_skid = bus.out_ready;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q <= '0;
            s_q <= '0;
        end else begin
            if (m_ld_in)        m_q <= dec_in;
            else if (m_ld_skid) m_q <= s_q;
            if (s_ld)           s_q <= dec_in;
        end
    end

    assign bus.in_ready  = in_rdy_q;
    assign bus.out_valid = (state_q != ST_EMPTY);
    assign bus.out_pc    = m_q.pc;
    assign bus.rs1       = m_q.f.rs1;
    assign bus.rs2       = m_q.f.rs2;
    assign bus.rd        = m_q.f.rd;
    assign bus.opcode    = m_q.f.opcode;
    assign bus.funct3    = m_q.f.funct3;
    assign bus.funct7    = m_q.f.funct7;
    assign bus.imm       = m_q.imm;
    assign bus.fmt       = m_q.fmt;
    assign bus.illegal   = m_q.illegal;

endmodule

// File: tb/tb_ifid_decode_stage.sv
// Directed bench for ifid_decode_stage: decode vector table on XLEN=32/64 plus handshake, flush and reset sequences.
module tb_ifid_decode_stage;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    ifid_decode_stage_if #(.XLEN(32)) bus ();
    ifid_decode_stage_if #(.XLEN(64)) bus64 ();

    ifid_decode_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ifid_decode_stage #(.XLEN(64)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  op;
        logic [2:0]  fmt;
        logic        ill;
        logic [63:0] imm64;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [31:0] inst, input logic [31:0] pc,
                         input logic fl, input logic ordy);
        bus.in_valid    = vld;
        bus.in_inst     = inst;
        bus.in_pc       = pc;
        bus.flush       = fl;
        bus.out_ready   = ordy;
        bus64.in_valid  = vld;
        bus64.in_inst   = inst;
        bus64.in_pc     = 64'(pc);
        bus64.flush     = fl;
        bus64.out_ready = ordy;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        vecs[0]  = '{32'hFFF10093, 5'd1,  5'd2,  5'd31, 7'h13, 3'd1, 1'b0, 64'hFFFFFFFF_FFFFFFFF};
        vecs[1]  = '{32'h00512423, 5'd8,  5'd2,  5'd5,  7'h23, 3'd2, 1'b0, 64'h00000000_00000008};
        vecs[2]  = '{32'h123452B7, 5'd5,  5'd8,  5'd3,  7'h37, 3'd4, 1'b0, 64'h00000000_12345000};
        vecs[3]  = '{32'h00000000, 5'd0,  5'd0,  5'd0,  7'h00, 3'd7, 1'b1, 64'h0};
        vecs[4]  = '{32'h0000007F, 5'd0,  5'd0,  5'd0,  7'h7F, 3'd7, 1'b1, 64'h0};
        vecs[5]  = '{32'hFE208EE3, 5'd29, 5'd1,  5'd2,  7'h63, 3'd3, 1'b0, 64'hFFFFFFFF_FFFFFFFC};
        vecs[6]  = '{32'hFF9FF0EF, 5'd1,  5'd31, 5'd25, 7'h6F, 3'd5, 1'b0, 64'hFFFFFFFF_FFFFFFF8};
        vecs[7]  = '{32'h002081B3, 5'd3,  5'd1,  5'd2,  7'h33, 3'd0, 1'b0, 64'h0};
        vecs[8]  = '{32'hFFF10091, 5'd1,  5'd2,  5'd31, 7'h11, 3'd7, 1'b1, 64'h0};
        vecs[9]  = '{32'hFE512E23, 5'd28, 5'd2,  5'd5,  7'h23, 3'd2, 1'b0, 64'hFFFFFFFF_FFFFFFFC};
        vecs[10] = '{32'h80000017, 5'd0,  5'd0,  5'd0,  7'h17, 3'd4, 1'b0, 64'hFFFFFFFF_80000000};

        // Reset values
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_out_pc",    64'(bus.out_pc),    64'd0);
        chk("rst_imm",       64'(bus.imm),       64'd0);
        chk("rst_fmt",       64'(bus.fmt),       64'd0);
        chk("rst_illegal",   64'(bus.illegal),   64'd0);
        chk("rst_rd",        64'(bus.rd),        64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Decode table at full throughput, one vector per cycle
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, vecs[i].inst, 32'h100 + 32'(i * 4), 1'b0, 1'b1);
            @(negedge clk);
            chk("tbl_out_valid", 64'(bus.out_valid), 64'd1);
            chk("tbl_in_ready",  64'(bus.in_ready),  64'd1);
            chk("tbl_out_pc",    64'(bus.out_pc),    64'(32'h100 + 32'(i * 4)));
            chk("tbl_rd",        64'(bus.rd),        64'(vecs[i].rd));
            chk("tbl_rs1",       64'(bus.rs1),       64'(vecs[i].rs1));
            chk("tbl_rs2",       64'(bus.rs2),       64'(vecs[i].rs2));
            chk("tbl_opcode",    64'(bus.opcode),    64'(vecs[i].op));
            chk("tbl_fmt",       64'(bus.fmt),       64'(vecs[i].fmt));
            chk("tbl_illegal",   64'(bus.illegal),   64'(vecs[i].ill));
            chk("tbl_imm32",     64'(bus.imm),       64'(vecs[i].imm64[31:0]));
            chk("tbl_imm64",     bus64.imm,          vecs[i].imm64);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk("drain_out_valid", 64'(bus.out_valid), 64'd0);

        // Back-pressure: 0x0 -> M, 0x4 -> S, 0x8 held, then drain in order
        drive(1'b1, 32'h00000013, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_one_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_one_pc",    64'(bus.out_pc),    64'h0);
        chk("bp_one_rdy",   64'(bus.in_ready),  64'd1);
        drive(1'b1, 32'h00000013, 32'h4, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_full_rdy",  64'(bus.in_ready),  64'd0);
        chk("bp_full_pc",   64'(bus.out_pc),    64'h0);
        drive(1'b1, 32'h00000013, 32'h8, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_hold_rdy",  64'(bus.in_ready),  64'd0);
        chk("bp_hold_pc",   64'(bus.out_pc),    64'h0);
        chk("bp_hold_vld",  64'(bus.out_valid), 64'd1);
        drive(1'b1, 32'h00000013, 32'h8, 1'b0, 1'b1);
        @(negedge clk);
        chk("bp_pop1_vld",  64'(bus.out_valid), 64'd1);
        chk("bp_pop1_pc",   64'(bus.out_pc),    64'h4);
        chk("bp_pop1_rdy",  64'(bus.in_ready),  64'd1);
        @(negedge clk);
        chk("bp_pop2_vld",  64'(bus.out_valid), 64'd1);
        chk("bp_pop2_pc",   64'(bus.out_pc),    64'h8);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk("bp_end_vld",   64'(bus.out_valid), 64'd0);

        // Flush while FULL with a valid input present
        drive(1'b1, 32'h00000013, 32'h40, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h00000013, 32'h44, 1'b0, 1'b0);
        @(negedge clk);
        chk("fl_full_rdy",  64'(bus.in_ready),  64'd0);
        drive(1'b1, 32'h00000013, 32'h48, 1'b1, 1'b0);
        @(negedge clk);
        chk("fl_vld",       64'(bus.out_valid), 64'd0);
        chk("fl_rdy",       64'(bus.in_ready),  64'd1);
        // Flush in EMPTY with in_ready=1: the presented input must be dropped
        drive(1'b1, 32'h00000013, 32'h50, 1'b1, 1'b1);
        @(negedge clk);
        chk("fl2_vld",      64'(bus.out_valid), 64'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk("fl2_after_vld", 64'(bus.out_valid), 64'd0);
        // Flush in ONE with out_ready=1 and a valid input: both dropped
        drive(1'b1, 32'h00000013, 32'h60, 1'b0, 1'b0);
        @(negedge clk);
        chk("fl3_one_vld",  64'(bus.out_valid), 64'd1);
        drive(1'b1, 32'h00000013, 32'h64, 1'b1, 1'b1);
        @(negedge clk);
        chk("fl3_vld",      64'(bus.out_valid), 64'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Asynchronous reset while FULL
        @(negedge clk);
        drive(1'b1, 32'hFFF10093, 32'h70, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'hFFF10093, 32'h74, 1'b0, 1'b0);
        @(negedge clk);
        chk("ar_full_vld",  64'(bus.out_valid), 64'd1);
        chk("ar_full_imm",  64'(bus.imm),       64'hFFFFFFFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_vld",       64'(bus.out_valid), 64'd0);
        chk("ar_rdy",       64'(bus.in_ready),  64'd1);
        chk("ar_pc",        64'(bus.out_pc),    64'd0);
        chk("ar_imm",       64'(bus.imm),       64'd0);
        chk("ar_imm64",     bus64.imm,          64'd0);
        chk("ar_rd",        64'(bus.rd),        64'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_post_vld",  64'(bus.out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
